mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (IF) and the load/store unit (LSU) of the RV64 core.
//  Accepts one request at a time, drives it onto the memory port with a valid/ready handshake and waits for the response.
//  Routes the response back to the requester that owns the transaction.
//  LSU has priority; a starvation counter guarantees IF forward progress.
// PARAMETERS
//  ADDR_W        64  request address width
//  DATA_W        64  read/write data width
//  STARVE_LIMIT  4   consecutive LSU grants while IF is waiting before IF is forced to win (>=1)
// PORTS
//  clk            in   1          clock, all state updates on posedge
//  rst            in   1          synchronous, active-high reset
//  if_req_valid   in   1          IF fetch request
//  if_req_ready   out  1          IF request accepted this cycle
//  if_req_addr    in   ADDR_W     fetch address
//  if_rsp_valid   out  1          IF response, 1-cycle pulse
//  if_rsp_rdata   out  DATA_W     fetch data, valid with if_rsp_valid
//  lsu_req_valid  in   1          LSU request
//  lsu_req_ready  out  1          LSU request accepted this cycle
//  lsu_req_addr   in   ADDR_W     load/store address
//  lsu_req_wen    in   1          1 = store, 0 = load
//  lsu_req_wdata  in   DATA_W     store data
//  lsu_req_wmask  in   DATA_W/8   store byte mask
//  lsu_rsp_valid  out  1          LSU response (load data or store ack), 1-cycle pulse
//  lsu_rsp_rdata  out  DATA_W     load data, valid with lsu_rsp_valid
//  mem_req_valid  out  1          memory request valid
//  mem_req_ready  in   1          memory accepts request
//  mem_req_addr   out  ADDR_W     latched address
//  mem_req_wen    out  1          latched write enable (0 for IF)
//  mem_req_wdata  out  DATA_W     latched store data (0 for IF)
//  mem_req_wmask  out  DATA_W/8   latched byte mask (0 for IF)
//  mem_rsp_valid  in   1          memory response, 1-cycle pulse, also acks stores
//  mem_rsp_rdata  in   DATA_W     memory read data
// BEHAVIOUR
//  FSM: IDLE -> REQ -> WAIT -> IDLE, one outstanding transaction max.
//   IDLE: arbitrate.
//    - Winner = LSU if lsu_req_valid and starve_cnt < STARVE_LIMIT; else IF if if_req_valid; else LSU if lsu_req_valid.
//    - Winner's *_req_ready = 1 (combinational, IDLE only; loser's ready = 0).
//    - On valid&ready: latch addr/wen/wdata/wmask (IF: wen, wdata, wmask = 0) and owner bit; go to REQ.
//   REQ: mem_req_valid = 1; mem_req_* driven from latches, stable until accepted.
//    - mem_req_valid & mem_req_ready -> WAIT.
//   WAIT: mem_rsp_valid -> owner's *_rsp_valid = 1 same cycle (combinational pass-through); go to IDLE.
//    - *_rsp_rdata = mem_rsp_rdata for the owner, 0 for the other.
//  mem_rsp_valid in IDLE or REQ: ignored. Memory responds no earlier than the cycle after acceptance.
//  Requester inputs ignored outside IDLE; requesters hold valid until ready.
//  starve_cnt: width $clog2(STARVE_LIMIT+1).
//   - +1 on an LSU grant while if_req_valid = 1.
//   - Cleared on an IF grant, or in any IDLE cycle with if_req_valid = 0.
//   - Saturates at STARVE_LIMIT.
//  Latency, ideal memory: accept at T, mem_req_valid at T+1 (mem_req_ready = 1), response at T+2 earliest,
//   next accept at T+3. No bubble beyond the IDLE cycle.
//  Reset (also mid-transaction): state = IDLE, starve_cnt = 0, latches = 0, owner = IF.
//   All *_ready/*_valid outputs 0 during rst. In-flight transaction dropped; memory is reset by the same rst.
// TESTING
//  1. IF-only read 0x8000_0000, mem_req_ready = 1, rsp 0x13 two cycles later
//     -> if_req_ready at T, mem_req_valid at T+1 with wen = 0, if_rsp_valid with rdata 0x13 at T+2.
//  2. IF and LSU store (addr 0x100, wdata 0xDEAD, wmask 0xFF) valid together
//     -> LSU granted first, mem_req_wen = 1; lsu_rsp_valid on ack; IF granted next IDLE.
//  3. LSU valid every IDLE plus IF held valid, STARVE_LIMIT = 4
//     -> 4 LSU grants, then IF granted as the 5th; starve_cnt returns to 0.
//  4. mem_req_ready low 3 cycles in REQ
//     -> mem_req_valid and addr/wdata stay constant for 3 cycles, accepted on cycle 4.
//  5. Spurious mem_rsp_valid in IDLE and REQ -> no *_rsp_valid pulse, FSM state unchanged.
//  6. rst asserted in WAIT -> next cycle IDLE, no rsp pulse; a new IF request is accepted immediately after rst drops.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, LSU) and memory-port signals around the shared memory-port arbiter.
// The master modport is the arbiter's view; slave is the environment around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_rsp_valid;
    logic [DATA_W-1:0] lsu_rsp_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    modport master (
        input  if_req_valid, if_req_addr,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );

    modport slave (
        output if_req_valid, if_req_addr,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and the LSU.
// LSU wins by default; a starvation counter forces an IF grant after STARVE_LIMIT LSU wins.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic [CNT_W-1:0]  starve_cnt_nxt_s;
    logic              owner_lsu_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wen_r;
    logic [DATA_W-1:0] wdata_r;
    logic [MASK_W-1:0] wmask_r;

    logic              pick_lsu_s;
    logic              pick_if_s;
    logic              idle_s;
    logic              grant_lsu_s;
    logic              grant_if_s;
    logic              rsp_fire_s;

    // Priority pick: LSU unless IF has been starved, then IF, then LSU as fallback
    always_comb begin
        pick_lsu_s = 1'b0;
        pick_if_s  = 1'b0;
        if (bus.lsu_req_valid && (starve_cnt_r < LIMIT_C)) begin
            pick_lsu_s = 1'b1;
        end else if (bus.if_req_valid) begin
            pick_if_s = 1'b1;
        end else if (bus.lsu_req_valid) begin
            pick_lsu_s = 1'b1;
        end else begin
            pick_lsu_s = 1'b0;
            pick_if_s  = 1'b0;
        end
    end

    // Requests are only accepted in IDLE and never while reset is held
    assign idle_s      = (state_r == ST_IDLE) && !rst;
    assign grant_lsu_s = idle_s && pick_lsu_s;
    assign grant_if_s  = idle_s && pick_if_s;
    assign rsp_fire_s  = (state_r == ST_WAIT) && bus.mem_rsp_valid && !rst;

    // Starvation counter update: counts LSU wins over a waiting IF, saturating
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (grant_if_s) begin
            starve_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (idle_s && !bus.if_req_valid) begin
            starve_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (grant_lsu_s) begin
            if (starve_cnt_r < LIMIT_C) begin
                starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_nxt_s = starve_cnt_r;
            end
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Transaction sequencing: IDLE -> REQ -> WAIT -> IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_lsu_s || grant_if_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request-side outputs: ready is a pure IDLE decode, memory request comes from the latches
    always_comb begin
        bus.if_req_ready  = grant_if_s;
        bus.lsu_req_ready = grant_lsu_s;
        bus.mem_req_valid = (state_r == ST_REQ) && !rst;
        bus.mem_req_addr  = addr_r;
        bus.mem_req_wen   = wen_r;
        bus.mem_req_wdata = wdata_r;
        bus.mem_req_wmask = wmask_r;
    end

    // Response routing: the memory response passes straight through to the owner only
    always_comb begin
        bus.if_rsp_valid  = 1'b0;
        bus.if_rsp_rdata  = {DATA_W{1'b0}};
        bus.lsu_rsp_valid = 1'b0;
        bus.lsu_rsp_rdata = {DATA_W{1'b0}};
        if (rsp_fire_s) begin
            if (owner_lsu_r) begin
                bus.lsu_rsp_valid = 1'b1;
                bus.lsu_rsp_rdata = bus.mem_rsp_rdata;
            end else begin
                bus.if_rsp_valid = 1'b1;
                bus.if_rsp_rdata = bus.mem_rsp_rdata;
            end
        end else begin
            bus.if_rsp_valid  = 1'b0;
            bus.lsu_rsp_valid = 1'b0;
        end
    end

    // State, starvation history and granted-request latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= {CNT_W{1'b0}};
            owner_lsu_r  <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wen_r        <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            wmask_r      <= {MASK_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            if (grant_lsu_s) begin
                owner_lsu_r <= 1'b1;
                addr_r      <= bus.lsu_req_addr;
                wen_r       <= bus.lsu_req_wen;
                wdata_r     <= bus.lsu_req_wdata;
                wmask_r     <= bus.lsu_req_wmask;
            end else if (grant_if_s) begin
                // Fetches are always plain reads
                owner_lsu_r <= 1'b0;
                addr_r      <= bus.if_req_addr;
                wen_r       <= 1'b0;
                wdata_r     <= {DATA_W{1'b0}};
                wmask_r     <= {MASK_W{1'b0}};
            end else begin
                owner_lsu_r <= owner_lsu_r;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;
    localparam int LIMIT  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = '0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_wdata = '0;
        bus.lsu_req_wmask = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.if_req_valid  = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (bus.if_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_if_ready got %0b want 0", bus.if_req_ready); end
        n_cmp++; if (bus.lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_lsu_ready got %0b want 0", bus.lsu_req_ready); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid got %0b want 0", bus.mem_req_valid); end
        n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid got %b want 00", {bus.if_rsp_valid, bus.lsu_rsp_valid}); end
        n_cmp++; if (bus.mem_req_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", bus.mem_req_addr); end
        step();
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_if_read();
        do_reset();
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'h8000_0000;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.if_req_ready, bus.lsu_req_ready} !== 2'b10) begin n_err++; $display("FAIL t1_ready got %b want 10", {bus.if_req_ready, bus.lsu_req_ready}); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL t1_memv_T got %0b want 0", bus.mem_req_valid); end
        step();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL t1_memv_T1 got %0b want 1", bus.mem_req_valid); end
        n_cmp++; if (bus.mem_req_wen !== 1'b0) begin n_err++; $display("FAIL t1_wen got %0b want 0", bus.mem_req_wen); end
        n_cmp++; if (bus.mem_req_addr !== 64'h8000_0000) begin n_err++; $display("FAIL t1_addr got %h want 80000000", bus.mem_req_addr); end
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 64'h13;
        @(negedge clk);
        n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL t1_rspv got %b want 10", {bus.if_rsp_valid, bus.lsu_rsp_valid}); end
        n_cmp++; if (bus.if_rsp_rdata !== 64'h13) begin n_err++; $display("FAIL t1_rdata got %h want 13", bus.if_rsp_rdata); end
        n_cmp++; if (bus.lsu_rsp_rdata !== 64'h0) begin n_err++; $display("FAIL t1_lsu_rdata got %h want 0", bus.lsu_rsp_rdata); end
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'h8000_0004;
        @(negedge clk);
        n_cmp++; if (bus.if_req_ready !== 1'b1) begin n_err++; $display("FAIL t1_next_accept got %0b want 1", bus.if_req_ready); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'h8000_0010;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h100;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = 64'hDEAD;
        bus.lsu_req_wmask = 8'hFF;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.if_req_ready, bus.lsu_req_ready} !== 2'b01) begin n_err++; $display("FAIL t2_ready got %b want 01", {bus.if_req_ready, bus.lsu_req_ready}); end
        step();
        bus.lsu_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.mem_req_valid, bus.mem_req_wen} !== 2'b11) begin n_err++; $display("FAIL t2_memv_wen got %b want 11", {bus.mem_req_valid, bus.mem_req_wen}); end
        n_cmp++; if ({bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask} !== {64'h100, 64'hDEAD, 8'hFF}) begin n_err++; $display("FAIL t2_fields got %h/%h/%h want 100/dead/ff", bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask); end
        n_cmp++; if (bus.if_req_ready !== 1'b0) begin n_err++; $display("FAIL t2_if_ready_busy got %0b want 0", bus.if_req_ready); end
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 64'h55;
        @(negedge clk);
        n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid} !== 2'b01) begin n_err++; $display("FAIL t2_ack got %b want 01", {bus.if_rsp_valid, bus.lsu_rsp_valid}); end
        step();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.if_req_ready, bus.lsu_req_ready} !== 2'b10) begin n_err++; $display("FAIL t2_if_next got %b want 10", {bus.if_req_ready, bus.lsu_req_ready}); end
        step();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask} !== {64'h8000_0010, 1'b0, 64'h0, 8'h00}) begin n_err++; $display("FAIL t2_if_fields got %h/%0b/%h/%h want 80000010/0/0/0", bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask); end
    endtask

    task automatic test_starvation();
        int  lsu_wins;
        bit  want_if;
        do_reset();
        lsu_wins = 0;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'hA000;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'hB000;
        bus.mem_req_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            want_if = (lsu_wins >= LIMIT);
            @(negedge clk);
            n_cmp++; if ({bus.if_req_ready, bus.lsu_req_ready} !== {want_if, !want_if}) begin n_err++; $display("FAIL t3_grant%0d got %b want %b", g, {bus.if_req_ready, bus.lsu_req_ready}, {want_if, !want_if}); end
            step();
            @(negedge clk);
            n_cmp++; if (bus.mem_req_addr !== (want_if ? 64'hA000 : 64'hB000)) begin n_err++; $display("FAIL t3_addr%0d got %h", g, bus.mem_req_addr); end
            step();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = 64'(g);
            @(negedge clk);
            n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid} !== {want_if, !want_if}) begin n_err++; $display("FAIL t3_rsp%0d got %b want %b", g, {bus.if_rsp_valid, bus.lsu_rsp_valid}, {want_if, !want_if}); end
            step();
            bus.mem_rsp_valid = 1'b0;
            lsu_wins = want_if ? 0 : lsu_wins + 1;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] r;
        do_reset();
        a = {$urandom, $urandom};
        d = {$urandom, $urandom};
        r = {$urandom, $urandom};
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = a;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = d;
        bus.lsu_req_wmask = 8'h0F;
        @(negedge clk);
        n_cmp++; if (bus.lsu_req_ready !== 1'b1) begin n_err++; $display("FAIL t4_grant got %0b want 1", bus.lsu_req_ready); end
        step();
        bus.lsu_req_addr  = ~a;
        bus.lsu_req_wdata = ~d;
        bus.if_req_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask} !== {1'b1, a, d, 8'h0F}) begin n_err++; $display("FAIL t4_hold%0d got v=%0b a=%h d=%h", k, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wdata); end
            n_cmp++; if ({bus.if_req_ready, bus.lsu_req_ready} !== 2'b00) begin n_err++; $display("FAIL t4_ready%0d got %b want 00", k, {bus.if_req_ready, bus.lsu_req_ready}); end
            step();
            bus.mem_req_ready = (k == 2);
        end
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL t4_accepted got %0b want 0", bus.mem_req_valid); end
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = r;
        @(negedge clk);
        n_cmp++; if ({bus.lsu_rsp_valid, bus.lsu_rsp_rdata} !== {1'b1, r}) begin n_err++; $display("FAIL t4_rsp got %0b/%h want 1/%h", bus.lsu_rsp_valid, bus.lsu_rsp_rdata, r); end
        step();
        clear_inputs();
    endtask

    task automatic test_spurious_rsp();
        do_reset();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 64'h1234;
        @(negedge clk);
        n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL t5_idle_rsp got %b want 00", {bus.if_rsp_valid, bus.lsu_rsp_valid}); end
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'hC000;
        @(negedge clk);
        n_cmp++; if (bus.if_req_ready !== 1'b1) begin n_err++; $display("FAIL t5_still_idle got %0b want 1", bus.if_req_ready); end
        step();
        bus.if_req_valid  = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.mem_req_valid, bus.if_rsp_valid, bus.lsu_rsp_valid} !== 3'b100) begin n_err++; $display("FAIL t5_req_rsp got %b want 100", {bus.mem_req_valid, bus.if_rsp_valid, bus.lsu_rsp_valid}); end
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL t5_still_req got %0b want 1", bus.mem_req_valid); end
        step();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 64'h77;
        @(negedge clk);
        n_cmp++; if ({bus.if_rsp_valid, bus.if_rsp_rdata} !== {1'b1, 64'h77}) begin n_err++; $display("FAIL t5_real_rsp got %0b/%h want 1/77", bus.if_rsp_valid, bus.if_rsp_rdata); end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_midtx();
        do_reset();
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'hD000;
        bus.mem_req_ready = 1'b1;
        step();
        bus.if_req_valid = 1'b0;
        step();
        rst = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 64'h99;
        @(negedge clk);
        n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid} !== 3'b000) begin n_err++; $display("FAIL t6_in_rst got %b want 000", {bus.if_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid}); end
        step();
        rst = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 64'hE000;
        @(negedge clk);
        n_cmp++; if ({bus.if_req_ready, bus.if_rsp_valid, bus.lsu_rsp_valid} !== 3'b100) begin n_err++; $display("FAIL t6_after_rst got %b want 100", {bus.if_req_ready, bus.if_rsp_valid, bus.lsu_rsp_valid}); end
        n_cmp++; if (bus.mem_req_addr !== 64'h0) begin n_err++; $display("FAIL t6_latch_clr got %h want 0", bus.mem_req_addr); end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        bit          if_hold, lsu_hold, busy, accepted, own_lsu, rsp_drv, want_if, want_lsu, want_memv;
        logic [63:0] if_a, lsu_a, lsu_d, rsp_data;
        logic        lsu_w;
        logic [7:0]  lsu_m;
        logic [136:0] want_req;
        int          waits, rsp_wait;
        do_reset();
        if_hold = 0; lsu_hold = 0; busy = 0; accepted = 0; own_lsu = 0;
        waits = 0; rsp_wait = 0; want_req = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!if_hold && ($urandom_range(0, 2) != 0)) begin
                if_hold = 1; if_a = {$urandom, $urandom};
            end
            if (!lsu_hold && ($urandom_range(0, 1) != 0)) begin
                lsu_hold = 1; lsu_a = {$urandom, $urandom}; lsu_d = {$urandom, $urandom};
                lsu_w = 1'($urandom); lsu_m = 8'($urandom);
            end
            bus.if_req_valid  = if_hold;
            bus.if_req_addr   = if_a;
            bus.lsu_req_valid = lsu_hold;
            bus.lsu_req_addr  = lsu_a;
            bus.lsu_req_wen   = lsu_w;
            bus.lsu_req_wdata = lsu_d;
            bus.lsu_req_wmask = lsu_m;
            bus.mem_req_ready = 1'($urandom);
            rsp_drv = 0;
            if (busy && accepted) begin
                rsp_wait--;
                rsp_drv = (rsp_wait == 0);
            end
            rsp_data = {$urandom, $urandom};
            bus.mem_rsp_valid = rsp_drv;
            bus.mem_rsp_rdata = rsp_data;
            @(negedge clk);
            want_if = 0; want_lsu = 0;
            if (!busy) begin
                if (lsu_hold && waits < LIMIT) want_lsu = 1;
                else if (if_hold) want_if = 1;
                else if (lsu_hold) want_lsu = 1;
            end
            want_memv = busy && !accepted;
            n_cmp++; if ({bus.if_req_ready, bus.lsu_req_ready} !== {want_if, want_lsu}) begin n_err++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, {bus.if_req_ready, bus.lsu_req_ready}, {want_if, want_lsu}); end
            n_cmp++; if (bus.mem_req_valid !== want_memv) begin n_err++; $display("FAIL rnd_memv c%0d got %0b want %0b", cyc, bus.mem_req_valid, want_memv); end
            if (want_memv) begin
                n_cmp++; if ({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask} !== want_req) begin n_err++; $display("FAIL rnd_req c%0d got a=%h w=%0b", cyc, bus.mem_req_addr, bus.mem_req_wen); end
            end
            n_cmp++; if ({bus.if_rsp_valid, bus.lsu_rsp_valid} !== {rsp_drv && !own_lsu, rsp_drv && own_lsu}) begin n_err++; $display("FAIL rnd_rspv c%0d got %b", cyc, {bus.if_rsp_valid, bus.lsu_rsp_valid}); end
            if (rsp_drv) begin
                n_cmp++; if ((own_lsu ? {bus.lsu_rsp_rdata, bus.if_rsp_rdata} : {bus.if_rsp_rdata, bus.lsu_rsp_rdata}) !== {rsp_data, 64'h0}) begin n_err++; $display("FAIL rnd_rdata c%0d got if=%h lsu=%h want %h", cyc, bus.if_rsp_rdata, bus.lsu_rsp_rdata, rsp_data); end
            end
            if (rsp_drv) begin
                busy = 0; accepted = 0;
            end else if (want_memv && bus.mem_req_ready) begin
                accepted = 1; rsp_wait = $urandom_range(1, 4);
            end
            if (want_if) begin
                busy = 1; accepted = 0; own_lsu = 0; if_hold = 0; waits = 0;
                want_req = {if_a, 1'b0, 64'h0, 8'h00};
            end else if (want_lsu) begin
                busy = 1; accepted = 0; own_lsu = 1; lsu_hold = 0;
                want_req = {lsu_a, lsu_w, lsu_d, lsu_m};
                waits = if_hold ? ((waits + 1 > LIMIT) ? LIMIT : waits + 1) : 0;
            end else if (!busy && !if_hold) begin
                waits = 0;
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_if_read();
        test_priority();
        test_starvation();
        test_backpressure();
        test_spurious_rsp();
        test_reset_midtx();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
